// File: rtl/fp_mul_seq_pkg.sv
// Shared float-point types, constants and classification helpers used by the
// sequential multiplier and its testbench.
package fp_mul_seq_pkg;

  localparam int unsigned EXPONENT_BITS = 8;
  localparam int unsigned FRACTION_BITS = 23;
  localparam int          BIAS          = 127;
  localparam logic [31:0] QNAN          = 32'h7FC00000;

  typedef struct packed {
    logic                     sign;
    logic [EXPONENT_BITS-1:0] exponent;
    logic [FRACTION_BITS-1:0] fraction;
  } float_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
  } flags_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    MULT  = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } fpmul_state_t;

  function automatic logic iszero(input float_t f);
    return (f.exponent == '0) && (f.fraction == '0);
  endfunction

  function automatic logic isdenorm(input float_t f);
    return (f.exponent == '0) && (f.fraction != '0);
  endfunction

  function automatic logic isnan(input float_t f);
    return (f.exponent == '1) && (f.fraction != '0);
  endfunction

  function automatic logic isinfinity(input float_t f);
    return (f.exponent == '1) && (f.fraction == '0);
  endfunction

endpackage

// File: rtl/fp_mul_seq_if.sv
// Operand/result handshake bundle for the sequential float multiplier.
interface fp_mul_seq_if;
  import fp_mul_seq_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  flags_t      flags;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags, busy
  );

endinterface

// File: rtl/fp_mul_seq_mant.sv
// 24x24 shift-add mantissa multiplier, one multiplier bit per cycle, 24 steps.
// Only the upper 25 product bits leave the unit; the rest only feed the shift.
module fp_mant_mul_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] mcand,
  input  logic [23:0] mplier,
  output logic        done,
  output logic [24:0] prod_hi
);

  logic [47:0] prod_q, prod_d;
  logic [23:0] mcand_q, mcand_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic [24:0] partial;

  always_comb begin
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    // multiplier sits in the low half and is consumed LSB first as it shifts out
    partial = {1'b0, prod_q[47:24]} + {1'b0, (prod_q[0] ? mcand_q : 24'd0)};
    if (start) begin
      prod_d  = {24'd0, mplier};
      mcand_d = mcand;
      cnt_d   = 5'd0;
      run_d   = 1'b1;
    end else if (run_q) begin
      prod_d = {partial, prod_q[23:1]};
      if (cnt_q == 5'd23) begin
        cnt_d = 5'd0;
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

  assign done    = run_q && (cnt_q == 5'd23);
  assign prod_hi = prod_q[47:23];

endmodule

// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754 single multiplier: truncating, denormals flushed to zero.
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   CHECK | classify operands, resolve special cases
//   MULT  | 24-step mantissa multiply in progress
//   NORM  | normalise, range-check exponent, pack
//   DONE  | result presented until out_ready
module fp_mul_seq
  import fp_mul_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  fp_mul_seq_if.slave bus
);

  fpmul_state_t      state_q, state_d;
  float_t            a_q, a_d, b_q, b_d;
  logic [31:0]       result_q, result_d;
  flags_t            flags_q, flags_d;
  logic signed [9:0] exp_q, exp_d;

  logic              mul_start, mul_done;
  logic [24:0]       prod_hi;
  logic              sign;
  logic              a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  logic signed [9:0] exp_norm;
  logic [22:0]       frac_norm;

  fp_mant_mul_iter u_mant (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .mcand   ({1'b1, a_q.fraction}),
    .mplier  ({1'b1, b_q.fraction}),
    .done    (mul_done),
    .prod_hi (prod_hi)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    flags_d   = flags_q;
    exp_d     = exp_q;
    mul_start = 1'b0;

    sign   = a_q.sign ^ b_q.sign;
    a_zero = iszero(a_q) || isdenorm(a_q);
    b_zero = iszero(b_q) || isdenorm(b_q);
    a_nan  = isnan(a_q);
    b_nan  = isnan(b_q);
    a_inf  = isinfinity(a_q);
    b_inf  = isinfinity(b_q);

    exp_norm  = exp_q + $signed({9'd0, prod_hi[24]});
    frac_norm = prod_hi[24] ? prod_hi[23:1] : prod_hi[22:0];

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = CHECK;
        end
      end
      CHECK: begin
        flags_d = '0;
        state_d = DONE;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
          result_d        = QNAN;
          flags_d.invalid = 1'b1;
        end else if (a_inf || b_inf) begin
          result_d = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
          result_d = {sign, 31'd0};
        end else begin
          exp_d     = $signed({2'b00, a_q.exponent}) + $signed({2'b00, b_q.exponent})
                      - 10'sd127;
          mul_start = 1'b1;
          state_d   = MULT;
        end
      end
      MULT: begin
        if (mul_done) state_d = NORM;
      end
      NORM: begin
        flags_d = '0;
        if (exp_norm >= 10'sd255) begin
          result_d         = {sign, 8'hFF, 23'd0};
          flags_d.overflow = 1'b1;
        end else if (exp_norm <= 10'sd0) begin
          result_d          = {sign, 31'd0};
          flags_d.underflow = 1'b1;
        end else begin
          result_d = {sign, exp_norm[7:0], frac_norm};
        end
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      exp_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      exp_q    <= exp_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Randomised self-checking bench for fp_mul_seq against an integer-arithmetic float model.
module tb_fp_mul_seq;
  import fp_mul_seq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  fp_mul_seq_if bus ();

  fp_mul_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [2:0] f,
                                  output bit special);
    bit                s;
    int                ea, eb, e;
    longint unsigned   fa, fb, m, frac;
    bit                an, bn, ai, bi, az, bz;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    an = (ea == 255) && (fa != 0);
    bn = (eb == 255) && (fb != 0);
    ai = (ea == 255) && (fa == 0);
    bi = (eb == 255) && (fb == 0);
    az = (ea == 0);
    bz = (eb == 0);
    special = 1'b1;
    f = 3'b000;
    if (an || bn || (ai && bz) || (bi && az)) begin
      r = 32'h7FC00000;
      f = 3'b100;
    end else if (ai || bi) begin
      r = {s, 8'hFF, 23'd0};
    end else if (az || bz) begin
      r = {s, 31'd0};
    end else begin
      special = 1'b0;
      m = ((64'd1 << 23) + fa) * ((64'd1 << 23) + fb);
      e = ea + eb - 127;
      if (m >= (64'd1 << 47)) begin
        e++;
        frac = (m >> 24) & 64'h7FFFFF;
      end else begin
        frac = (m >> 23) & 64'h7FFFFF;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0};
        f = 3'b010;
      end else if (e <= 0) begin
        r = {s, 31'd0};
        f = 3'b001;
      end else begin
        r = {s, e[7:0], frac[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] fr;
    int          mode;
    mode = int'($urandom_range(0, 11));
    fr   = 23'($urandom());
    if (mode == 0)      e = 8'd0;
    else if (mode == 1) e = 8'd255;
    else if (mode == 2) e = 8'($urandom_range(1, 12));
    else if (mode == 3) e = 8'($urandom_range(240, 254));
    else                e = 8'($urandom_range(100, 154));
    if ($urandom_range(0, 7) == 0) fr = 23'd0;
    return {1'($urandom()), e, fr};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom();
    bus.b        = $urandom();
  endtask

  task automatic wait_result(input int lat0, input logic [31:0] er, input logic [2:0] ef,
                             input int el, input int hold, input string tag);
    int lat = lat0;
    while (!bus.out_valid && lat < 80) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) begin
      check({tag, "_timeout"}, 32'(bus.out_valid), 32'd1);
      return;
    end
    check({tag, "_latency"}, 32'(lat), 32'(el));
    check({tag, "_result"}, bus.result, er);
    check({tag, "_flags"}, 32'(bus.flags), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_result"}, bus.result, er);
      check({tag, "_hold_flags"}, 32'(bus.flags), 32'(ef));
      check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_drop_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                       input logic [2:0] ef, input int el, input int hold, input string tag);
    issue(a, b);
    wait_result(0, er, ef, el, hold, tag);
  endtask

  task automatic do_rand_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] er;
    logic [2:0]  ef;
    bit          sp;
    ref_mul(a, b, er, ef, sp);
    do_op(a, b, er, ef, sp ? 1 : 26, 0, tag);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op(32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 26, 0, "one_five_x_two");
    do_op(32'h7F800000, 32'h00000000, QNAN,          3'b100, 1,  0, "inf_x_zero");
    do_op(32'hBF800000, 32'h00000000, 32'h80000000, 3'b000, 1,  0, "neg_one_x_zero");
    do_op(32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010, 26, 0, "overflow");
    do_op(32'h00800000, 32'h00800000, 32'h00000000, 3'b001, 26, 0, "underflow");
    do_op(32'h7FC12345, 32'h3F800000, QNAN,          3'b100, 1,  0, "nan_in");
    do_op(32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 1,  0, "neg_inf");
    do_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 26, 5, "hold_stall");
    do_op(32'h40000000, 32'h40000000, 32'h40800000, 3'b000, 26, 0, "back_to_back");

    // abort mid-multiply: CHECK edge plus ten MULT steps after the accept
    issue(32'h3FC00000, 32'h40000000);
    repeat (11) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_result", bus.result, 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op(32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 26, 0, "after_abort");

    issue(32'h40400000, 32'h40400000);
    repeat (5) @(posedge clk);
    #2;
    bus.in_valid = 1'b1;
    bus.a        = 32'h7F800000;
    bus.b        = 32'h00000000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_result(6, 32'h41100000, 3'b000, 26, 0, "ignore_in_mult");

    for (int i = 0; i < 60; i++) begin
      do_rand_op(rand_op(), rand_op(), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
- Multi-cycle IEEE-754 single-precision multiplier with a valid/ready handshake on both input and output.
- An FSM sequences four phases: operand capture, special-case classification, a 24-step iterative mantissa multiply, and normalise/pack.
- Sits beside the floatingpoint package helpers, using the same float struct and classification rules.
- Rounding is truncation (round toward zero); denormal inputs and results are flushed to zero.

Parameters:
- EXPONENT_BITS, 8, exponent field width (package constant, not overridable per instance)
- FRACTION_BITS, 23, fraction field width (package constant)
- BIAS, 127, exponent bias

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  32  operand A (float)
- b  input  32  operand B (float)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  32  product (float)
- flags  output  3  {invalid, overflow, underflow}, valid with out_valid
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; result=0; flags=0; busy=0. Asserting reset in any state aborts the operation with no output.
- Accept: in_valid&&in_ready on edge E0 registers a and b, then moves to CHECK.
- CHECK (one cycle). Classification:
  - zero/denorm operands are treated as zero
  - NaN: exponent all ones, fraction nonzero
  - Inf: exponent all ones, fraction zero
- Result sign is always sa^sb, except for NaN.
- Special cases, checked in priority order, each going to DONE at E1:
  - any NaN → 32'h7FC00000, invalid=1
  - Inf×zero → 32'h7FC00000, invalid=1
  - any Inf → signed Inf
  - any zero → signed zero, flags=0
- Otherwise CHECK goes to MULT.
- MULT: shift-add of {1,fa} × {1,fb} (24×24 → 48 bits).
  - A 5-bit counter runs 0..23, one multiplier bit per cycle; exactly 24 cycles.
  - The exponent sum ea+eb−BIAS is computed in a 10-bit signed register.
- NORM (one cycle):
  - if prod[47]=1: fraction=prod[46:24], exp+=1; else fraction=prod[45:23]
  - exp ≥ 255 → signed Inf, overflow=1
  - exp ≤ 0 → signed zero, underflow=1
  - otherwise pack normally
- DONE: out_valid=1, with result and flags held stable.
  - Leaves to IDLE on the edge where out_ready=1; out_valid drops the next cycle.
  - in_ready returns to 1 in IDLE. Back-to-back: the next accept occurs no earlier than the cycle after the handshake.
- Latency, counted from the accept edge to the edge where out_valid rises:
  - special case: 1 edge (out_valid is seen in the cycle after accept, i.e. 2 cycles)
  - normal case: 26 edges (CHECK 1 + MULT 24 + NORM 1)
- Inputs a/b are ignored while not in IDLE.
- in_valid is not required to stay high after acceptance.

Decomposition:
- Add to the floatingpoint package:
  - constants BIAS=127 and QNAN=32'h7FC00000
  - typedef enum logic [2:0] {IDLE, CHECK, MULT, NORM, DONE} fpmul_state_t
  - typedef struct packed flags_t {invalid, overflow, underflow}
- Reuse the package functions iszero/isdenorm/isnan/isinfinity for classification.
- One sub-module: fp_mant_mul_iter.
  - 24×24 iterative shift-add unit with start/done, 48-bit product register and step counter.
  - Sequenced by the fp_mul_seq FSM.

Test Plan:
- 32'h3FC00000 × 32'h40000000 (1.5×2.0) → result 32'h40400000, flags=0, out_valid 26 edges after accept.
- 32'h7F800000 × 32'h00000000 (Inf×0) → result 32'h7FC00000, invalid=1, out_valid 1 edge after accept; 32'hBF800000 × 32'h00000000 → 32'h80000000.
- 32'h7F000000 × 32'h7F000000 → result 32'h7F800000, overflow=1; 32'h00800000 × 32'h00800000 → 32'h00000000, underflow=1.
- Hold out_ready=0 for 5 cycles after out_valid → result/flags stable, in_ready=0; raise out_ready → out_valid=0 next cycle, in_ready=1, and a second op (32'h40000000 × 32'h40000000 → 32'h40800000) completes.
- Assert reset while the counter is at step 10 → out_valid=0, result=0, in_ready=1 immediately, busy=0; a new op issued after reset completes correctly.
- Change a/b and pulse in_valid while in MULT → ignored; in-flight result is unchanged.
